// File: rtl/vx_wctl_recv.sv
// Warp-control receiver: per-warp active/thread masks, IPDOM split/join stacks,
// barrier arrival tracking and PC redirect generation, one command per cycle.
module vx_wctl_recv #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int IPDOM_DEPTH  = 4,
  parameter int XLEN         = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wctl_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]    wctl_wid,
  input  logic                            tmc_valid,
  input  logic [NUM_THREADS-1:0]          tmc_tmask,
  input  logic                            wspawn_valid,
  input  logic [NUM_WARPS-1:0]            wspawn_wmask,
  input  logic [XLEN-1:0]                 wspawn_pc,
  input  logic                            split_valid,
  input  logic                            split_is_dvg,
  input  logic [NUM_THREADS-1:0]          split_then_tmask,
  input  logic [NUM_THREADS-1:0]          split_else_tmask,
  input  logic [XLEN-1:0]                 split_next_pc,
  input  logic                            join_valid,
  input  logic                            join_is_dvg,
  input  logic                            bar_valid,
  input  logic [$clog2(NUM_BARRIERS)-1:0] bar_id,
  input  logic [$clog2(NUM_WARPS)-1:0]    bar_size_m1,
  output logic [NUM_WARPS-1:0]            active_mask,
  output logic [NUM_WARPS-1:0]            stalled_mask,
  input  logic [$clog2(NUM_WARPS)-1:0]    tmask_rd_wid,
  output logic [NUM_THREADS-1:0]          tmask_rd,
  output logic                            pc_upd_valid,
  output logic [NUM_WARPS-1:0]            pc_upd_wmask,
  output logic [XLEN-1:0]                 pc_upd_pc,
  output logic                            err_ovf,
  output logic                            err_unf
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam int PW = $clog2(IPDOM_DEPTH);
  localparam int OW = $clog2(IPDOM_DEPTH + 1);

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic                   fall;
  } ipdom_ent_t;

  logic [NUM_WARPS-1:0]   active_q, active_d;
  logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
  logic [OW-1:0]          occ_q [NUM_WARPS];
  logic [OW-1:0]          occ_d [NUM_WARPS];
  ipdom_ent_t             stk_q [NUM_WARPS][IPDOM_DEPTH];
  ipdom_ent_t             stk_d [NUM_WARPS][IPDOM_DEPTH];
  logic [WW-1:0]          bar_cnt_q [NUM_BARRIERS];
  logic [WW-1:0]          bar_cnt_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_mask_d [NUM_BARRIERS];
  logic                   pc_upd_valid_q, pc_upd_valid_d;
  logic [NUM_WARPS-1:0]   pc_upd_wmask_q, pc_upd_wmask_d;
  logic [XLEN-1:0]        pc_upd_pc_q, pc_upd_pc_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   err_unf_q, err_unf_d;

  logic [NUM_WARPS-1:0]   wid_oh;
  logic [OW-1:0]          cur_occ;
  ipdom_ent_t             top;

  always_comb begin
    active_d       = active_q;
    stalled_d      = stalled_q;
    tmask_d        = tmask_q;
    occ_d          = occ_q;
    stk_d          = stk_q;
    bar_cnt_d      = bar_cnt_q;
    bar_mask_d     = bar_mask_q;
    pc_upd_valid_d = 1'b0;
    pc_upd_wmask_d = pc_upd_wmask_q;
    pc_upd_pc_d    = pc_upd_pc_q;
    err_ovf_d      = err_ovf_q;
    err_unf_d      = err_unf_q;

    wid_oh           = '0;
    wid_oh[wctl_wid] = 1'b1;
    cur_occ          = occ_q[wctl_wid];
    // Index wraps harmlessly when the stack is empty; top is only used when occupied.
    top              = stk_q[wctl_wid][PW'(cur_occ - OW'(1))];

    if (wctl_valid) begin
      if (tmc_valid) begin
        tmask_d[wctl_wid]  = tmc_tmask;
        active_d[wctl_wid] = (tmc_tmask != '0);
      end else if (wspawn_valid) begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
          if (wspawn_wmask[w]) begin
            active_d[w] = 1'b1;
            tmask_d[w]  = NUM_THREADS'(1);
          end
        end
        pc_upd_valid_d = 1'b1;
        pc_upd_wmask_d = wspawn_wmask;
        pc_upd_pc_d    = wspawn_pc;
      end else if (split_valid) begin
        if (split_is_dvg) begin
          if (cur_occ <= OW'(IPDOM_DEPTH - 2)) begin
            stk_d[wctl_wid][PW'(cur_occ)] =
              '{tmask: tmask_q[wctl_wid], pc: '0, fall: 1'b1};
            stk_d[wctl_wid][PW'(cur_occ + OW'(1))] =
              '{tmask: split_else_tmask, pc: split_next_pc, fall: 1'b0};
            occ_d[wctl_wid]   = cur_occ + OW'(2);
            tmask_d[wctl_wid] = split_then_tmask;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      end else if (join_valid) begin
        if (join_is_dvg) begin
          if (cur_occ == '0) begin
            err_unf_d = 1'b1;
          end else begin
            occ_d[wctl_wid]   = cur_occ - OW'(1);
            tmask_d[wctl_wid] = top.tmask;
            if (!top.fall) begin
              pc_upd_valid_d = 1'b1;
              pc_upd_wmask_d = wid_oh;
              pc_upd_pc_d    = top.pc;
            end
          end
        end
      end else if (bar_valid) begin
        if (bar_cnt_q[bar_id] == bar_size_m1) begin
          stalled_d          = stalled_q & ~bar_mask_q[bar_id];
          bar_cnt_d[bar_id]  = '0;
          bar_mask_d[bar_id] = '0;
        end else begin
          bar_mask_d[bar_id] = bar_mask_q[bar_id] | wid_oh;
          bar_cnt_d[bar_id]  = bar_cnt_q[bar_id] + WW'(1);
          stalled_d[wctl_wid] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q       <= NUM_WARPS'(1);
      stalled_q      <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        tmask_q[w] <= (w == 0) ? '1 : '0;
        occ_q[w]   <= '0;
        for (int unsigned e = 0; e < IPDOM_DEPTH; e++) begin
          stk_q[w][e] <= '0;
        end
      end
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        bar_cnt_q[b]  <= '0;
        bar_mask_q[b] <= '0;
      end
      pc_upd_valid_q <= 1'b0;
      pc_upd_wmask_q <= '0;
      pc_upd_pc_q    <= '0;
      err_ovf_q      <= 1'b0;
      err_unf_q      <= 1'b0;
    end else begin
      active_q       <= active_d;
      stalled_q      <= stalled_d;
      tmask_q        <= tmask_d;
      occ_q          <= occ_d;
      stk_q          <= stk_d;
      bar_cnt_q      <= bar_cnt_d;
      bar_mask_q     <= bar_mask_d;
      pc_upd_valid_q <= pc_upd_valid_d;
      pc_upd_wmask_q <= pc_upd_wmask_d;
      pc_upd_pc_q    <= pc_upd_pc_d;
      err_ovf_q      <= err_ovf_d;
      err_unf_q      <= err_unf_d;
    end
  end

  assign active_mask  = active_q;
  assign stalled_mask = stalled_q;
  assign tmask_rd     = tmask_q[tmask_rd_wid];
  assign pc_upd_valid = pc_upd_valid_q;
  assign pc_upd_wmask = pc_upd_wmask_q;
  assign pc_upd_pc    = pc_upd_pc_q;
  assign err_ovf      = err_ovf_q;
  assign err_unf      = err_unf_q;

endmodule

// File: tb/tb_vx_wctl_recv.sv
// Bench for vx_wctl_recv: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vx_wctl_recv;

  logic        clk = 1'b0;
  logic        reset;
  logic        wctl_valid;
  logic [1:0]  wctl_wid;
  logic        tmc_valid;
  logic [3:0]  tmc_tmask;
  logic        wspawn_valid;
  logic [3:0]  wspawn_wmask;
  logic [31:0] wspawn_pc;
  logic        split_valid, split_is_dvg;
  logic [3:0]  split_then_tmask, split_else_tmask;
  logic [31:0] split_next_pc;
  logic        join_valid, join_is_dvg;
  logic        bar_valid;
  logic [1:0]  bar_id;
  logic [1:0]  bar_size_m1;
  logic [3:0]  active_mask, stalled_mask;
  logic [1:0]  tmask_rd_wid;
  logic [3:0]  tmask_rd;
  logic        pc_upd_valid;
  logic [3:0]  pc_upd_wmask;
  logic [31:0] pc_upd_pc;
  logic        err_ovf, err_unf;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  vx_wctl_recv #(
    .NUM_WARPS(4), .NUM_THREADS(4), .NUM_BARRIERS(4), .IPDOM_DEPTH(4), .XLEN(32)
  ) dut (
    .clk(clk), .reset(reset), .wctl_valid(wctl_valid), .wctl_wid(wctl_wid),
    .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
    .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
    .split_next_pc(split_next_pc),
    .join_valid(join_valid), .join_is_dvg(join_is_dvg),
    .bar_valid(bar_valid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
    .active_mask(active_mask), .stalled_mask(stalled_mask),
    .tmask_rd_wid(tmask_rd_wid), .tmask_rd(tmask_rd),
    .pc_upd_valid(pc_upd_valid), .pc_upd_wmask(pc_upd_wmask), .pc_upd_pc(pc_upd_pc),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // Reference model: per-warp stacks are plain queues, barriers are counters.
  typedef struct packed {
    logic [3:0]  tm;
    logic [31:0] pc;
    logic        fall;
  } ent_t;

  logic [3:0]  m_active  = 4'b0001;
  logic [3:0]  m_stalled = 4'b0000;
  logic [3:0]  m_tmask [4] = '{4'hF, 4'h0, 4'h0, 4'h0};
  ent_t        m_stk [4][$];
  int          m_bcnt [4] = '{0, 0, 0, 0};
  logic [3:0]  m_bmask [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic        m_pcv = 1'b0;
  logic [3:0]  m_pcw = 4'h0;
  logic [31:0] m_pcpc = 32'h0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  ent_t        m_e;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 4'b0001;
      m_stalled = 4'b0000;
      for (int w = 0; w < 4; w++) begin
        m_tmask[w] = (w == 0) ? 4'hF : 4'h0;
        m_stk[w].delete();
      end
      for (int b = 0; b < 4; b++) begin
        m_bcnt[b] = 0;
        m_bmask[b] = 4'h0;
      end
      m_pcv = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_pcv = 1'b0;
      if (wctl_valid) begin
        if (tmc_valid) begin
          m_tmask[wctl_wid] = tmc_tmask;
          m_active[wctl_wid] = (tmc_tmask != 4'h0);
        end else if (wspawn_valid) begin
          for (int w = 0; w < 4; w++)
            if (wspawn_wmask[w]) begin
              m_active[w] = 1'b1;
              m_tmask[w] = 4'b0001;
            end
          m_pcv = 1'b1; m_pcw = wspawn_wmask; m_pcpc = wspawn_pc;
        end else if (split_valid) begin
          if (split_is_dvg) begin
            if (m_stk[wctl_wid].size() + 2 <= 4) begin
              m_stk[wctl_wid].push_back('{tm: m_tmask[wctl_wid], pc: 32'h0, fall: 1'b1});
              m_stk[wctl_wid].push_back('{tm: split_else_tmask, pc: split_next_pc, fall: 1'b0});
              m_tmask[wctl_wid] = split_then_tmask;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end else if (join_valid) begin
          if (join_is_dvg) begin
            if (m_stk[wctl_wid].size() == 0) begin
              m_unf = 1'b1;
            end else begin
              m_e = m_stk[wctl_wid].pop_back();
              m_tmask[wctl_wid] = m_e.tm;
              if (!m_e.fall) begin
                m_pcv = 1'b1; m_pcw = 4'b0001 << wctl_wid; m_pcpc = m_e.pc;
              end
            end
          end
        end else if (bar_valid) begin
          if (m_bcnt[bar_id] == int'(bar_size_m1)) begin
            for (int w = 0; w < 4; w++)
              if (m_bmask[bar_id][w]) m_stalled[w] = 1'b0;
            m_bcnt[bar_id] = 0;
            m_bmask[bar_id] = 4'h0;
          end else begin
            m_bmask[bar_id][wctl_wid] = 1'b1;
            m_bcnt[bar_id] = m_bcnt[bar_id] + 1;
            m_stalled[wctl_wid] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("active_mask", active_mask, m_active);
      chk("stalled_mask", stalled_mask, m_stalled);
      chk("pc_upd_valid", pc_upd_valid, m_pcv);
      if (m_pcv) begin
        chk("pc_upd_wmask", pc_upd_wmask, m_pcw);
        chk("pc_upd_pc", pc_upd_pc, m_pcpc);
      end
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_unf", err_unf, m_unf);
      for (int w = 0; w < 4; w++) begin
        tmask_rd_wid = 2'(w);
        #1;
        chk($sformatf("tmask_rd[%0d]", w), tmask_rd, m_tmask[w]);
      end
    end
  end

  task automatic clear_all();
    wctl_valid = 1'b0; tmc_valid = 1'b0; wspawn_valid = 1'b0;
    split_valid = 1'b0; join_valid = 1'b0; bar_valid = 1'b0;
  endtask

  task automatic fire();
    wctl_valid = 1'b1;
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic do_tmc(input logic [1:0] wid, input logic [3:0] m);
    wctl_wid = wid; tmc_valid = 1'b1; tmc_tmask = m; fire();
  endtask

  task automatic do_wspawn(input logic [1:0] wid, input logic [3:0] wm, input logic [31:0] pc);
    wctl_wid = wid; wspawn_valid = 1'b1; wspawn_wmask = wm; wspawn_pc = pc; fire();
  endtask

  task automatic do_split(input logic [1:0] wid, input logic dvg, input logic [3:0] t,
                          input logic [3:0] e, input logic [31:0] pc);
    wctl_wid = wid; split_valid = 1'b1; split_is_dvg = dvg;
    split_then_tmask = t; split_else_tmask = e; split_next_pc = pc; fire();
  endtask

  task automatic do_join(input logic [1:0] wid, input logic dvg);
    wctl_wid = wid; join_valid = 1'b1; join_is_dvg = dvg; fire();
  endtask

  task automatic do_bar(input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sm1);
    wctl_wid = wid; bar_valid = 1'b1; bar_id = id; bar_size_m1 = sm1; fire();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    wctl_wid = 2'd0; tmc_tmask = 4'h0; wspawn_wmask = 4'h0; wspawn_pc = 32'h0;
    split_is_dvg = 1'b0; split_then_tmask = 4'h0; split_else_tmask = 4'h0;
    split_next_pc = 32'h0; join_is_dvg = 1'b0; bar_id = 2'd0; bar_size_m1 = 2'd0;
    clear_all();
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; chk_en = 1'b1;
    chk("rst_active", active_mask, 4'b0001);
    chk("rst_stalled", stalled_mask, 4'b0000);
    chk("rst_pcv", pc_upd_valid, 1'b0);
    chk("rst_model_tmask0", m_tmask[0], 4'hF);

    // Spawn warps 1..3
    do_wspawn(2'd0, 4'b1110, 32'h8000_0100);
    chk("spawn_active", active_mask, 4'b1111);
    chk("spawn_pcv", pc_upd_valid, 1'b1);
    chk("spawn_wmask", pc_upd_wmask, 4'b1110);
    chk("spawn_pc", pc_upd_pc, 32'h8000_0100);
    chk("spawn_model_tmask3", m_tmask[3], 4'b0001);
    @(posedge clk); #1;
    chk("spawn_pulse", pc_upd_valid, 1'b0);

    // Divergent split then two joins
    do_split(2'd0, 1'b1, 4'b0011, 4'b1100, 32'h200);
    chk("split_model_tmask", m_tmask[0], 4'b0011);
    do_join(2'd0, 1'b1);
    chk("join1_model_tmask", m_tmask[0], 4'b1100);
    chk("join1_pcv", pc_upd_valid, 1'b1);
    chk("join1_pc", pc_upd_pc, 32'h200);
    chk("join1_wmask", pc_upd_wmask, 4'b0001);
    do_join(2'd0, 1'b1);
    chk("join2_model_tmask", m_tmask[0], 4'b1111);
    chk("join2_pcv", pc_upd_valid, 1'b0);
    chk("join2_unf", err_unf, 1'b0);

    // Overflow at depth 4, underflow on warp 1
    do_split(2'd0, 1'b1, 4'b0001, 4'b1110, 32'h300);
    do_split(2'd0, 1'b1, 4'b0010, 4'b1101, 32'h400);
    chk("split2_ovf", err_ovf, 1'b0);
    do_split(2'd0, 1'b1, 4'b0100, 4'b1011, 32'h500);
    chk("split3_ovf", err_ovf, 1'b1);
    chk("split3_model_tmask", m_tmask[0], 4'b0010);
    do_split(2'd0, 1'b0, 4'b1000, 4'b0111, 32'h600);
    do_join(2'd1, 1'b0);
    do_join(2'd1, 1'b1);
    chk("unf_set", err_unf, 1'b1);

    // Barrier id 2, size 3
    do_bar(2'd0, 2'd2, 2'd2);
    do_bar(2'd1, 2'd2, 2'd2);
    chk("bar_two", stalled_mask, 4'b0011);
    chk("bar_two_active", active_mask, 4'b1111);
    do_bar(2'd3, 2'd2, 2'd2);
    chk("bar_release", stalled_mask, 4'b0000);
    do_bar(2'd2, 2'd2, 2'd2);
    chk("bar_restart", stalled_mask, 4'b0100);
    do_bar(2'd0, 2'd1, 2'd0);
    chk("bar_size1", stalled_mask, 4'b0100);

    // tmc on a stalled warp, priority, ignored command without wctl_valid
    do_tmc(2'd2, 4'b0000);
    chk("tmc_zero_active", active_mask, 4'b1011);
    chk("tmc_zero_stalled", stalled_mask, 4'b0100);
    wctl_wid = 2'd0; tmc_tmask = 4'b0101; join_is_dvg = 1'b1;
    tmc_valid = 1'b1; join_valid = 1'b1; fire();
    chk("prio_model_tmask", m_tmask[0], 4'b0101);
    chk("prio_model_depth", m_stk[0].size(), 64'd4);
    chk("prio_pcv", pc_upd_valid, 1'b0);
    wctl_wid = 2'd1; tmc_tmask = 4'b0000; tmc_valid = 1'b1;
    @(posedge clk); #1; clear_all();
    chk("no_wctl_active", active_mask, 4'b1011);
    do_join(2'd0, 1'b1);
    chk("join_else_pc", pc_upd_pc, 32'h400);
    chk("join_else_model_tmask", m_tmask[0], 4'b1101);

    // Reset with a command pending, barrier pending and stack occupied
    reset = 1'b0; wctl_wid = 2'd0; tmc_tmask = 4'h0; tmc_valid = 1'b1; wctl_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; clear_all();
    chk("rst2_active", active_mask, 4'b0001);
    chk("rst2_stalled", stalled_mask, 4'b0000);
    chk("rst2_ovf", err_ovf, 1'b0);
    chk("rst2_unf", err_unf, 1'b0);
    chk("rst2_model_tmask0", m_tmask[0], 4'hF);
    do_join(2'd0, 1'b1);
    chk("rst2_stack_empty", err_unf, 1'b1);
    do_bar(2'd1, 2'd2, 2'd1);
    chk("rst2_bar_cleared", stalled_mask, 4'b0010);
    do_bar(2'd0, 2'd2, 2'd1);
    chk("rst2_bar_release", stalled_mask, 4'b0000);

    repeat (2) @(posedge clk);
    #1; chk_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_wctl_recv.md
VX_WCTL_RECV -- requirements
Module: VX_wctl_recv

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_WARPS, 4, warps per core.
- NUM_THREADS, 4, threads per warp.
- NUM_BARRIERS, 4, barrier table entries.
- IPDOM_DEPTH, 4, IPDOM stack entries per warp (even, >=2).
- XLEN, 32, PC width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- wctl_valid, in, 1, warp-control command present this cycle.
- wctl_wid, in, clog2(NUM_WARPS), issuing warp.
- tmc_valid / tmc_tmask, in, 1 / NUM_THREADS, thread-mask set.
- wspawn_valid / wspawn_wmask / wspawn_pc, in, 1 / NUM_WARPS / XLEN, warp spawn.
- split_valid / split_is_dvg, in, 1 / 1, split.
- split_then_tmask / split_else_tmask, in, NUM_THREADS each, split masks.
- split_next_pc, in, XLEN, else-path PC.
- join_valid / join_is_dvg, in, 1 / 1, join.
- bar_valid / bar_id / bar_size_m1, in, 1 / clog2(NUM_BARRIERS) / clog2(NUM_WARPS), barrier arrival.
- active_mask, out, NUM_WARPS, warps eligible to schedule.
- stalled_mask, out, NUM_WARPS, warps held at a barrier.
- tmask_rd_wid, in, clog2(NUM_WARPS), thread-mask read select.
- tmask_rd, out, NUM_THREADS, combinational thread mask of tmask_rd_wid.
- pc_upd_valid / pc_upd_wmask / pc_upd_pc, out, 1 / NUM_WARPS / XLEN, PC redirect.
- err_ovf / err_unf, out, 1 each, sticky IPDOM overflow / underflow.

Function
REQ-003 A command SHALL be consumed only when wctl_valid=1; sub-valids are ignored otherwise; there is no back-pressure.
REQ-004 If multiple sub-valids are set, only the highest priority SHALL apply: tmc > wspawn > split > join > bar.
REQ-005 All state and outputs except tmask_rd SHALL be registered; effects SHALL be visible the cycle after the command.
REQ-006 tmc: tmask[wid] <= tmc_tmask; active[wid] <= (tmc_tmask != 0).
REQ-007 wspawn: for each set bit w of wspawn_wmask, active[w] <= 1 and tmask[w] <= 1 (thread 0 only).
REQ-007a wspawn: next cycle pc_upd_valid=1, pc_upd_wmask=wspawn_wmask, pc_upd_pc=wspawn_pc.
REQ-008 pc_upd_valid SHALL be a one-cycle pulse; pc_upd_wmask and pc_upd_pc are don't-care when it is 0.
REQ-009 split, is_dvg=0: no state change.
REQ-009a split, is_dvg=1, occupancy <= IPDOM_DEPTH-2: push {tmask[wid], pc=0, fall=1}, then push {split_else_tmask, split_next_pc, fall=0}, both in one cycle; tmask[wid] <= split_then_tmask.
REQ-010 split, is_dvg=1, occupancy > IPDOM_DEPTH-2: nothing pushed, tmask unchanged, err_ovf <= 1 (sticky).
REQ-011 join, is_dvg=0: no-op.
REQ-011a join, is_dvg=1: pop the top entry; tmask[wid] <= entry.tmask.
REQ-011b join with fall=0 in the popped entry: next cycle pc_upd_valid=1, pc_upd_wmask=onehot(wid), pc_upd_pc=entry.pc.
REQ-012 join with is_dvg=1 on an empty stack: no-op; err_unf <= 1 (sticky).
REQ-013 Barrier per id: arrival counter (clog2(NUM_WARPS) bits) and warp mask.
REQ-013a On bar when count != bar_size_m1: mask |= onehot(wid), count++, stalled[wid] <= 1.
REQ-014 On bar when count == bar_size_m1: release; stalled <= stalled & ~mask for that id; count and mask cleared; arriving warp not stalled. Consequently size_m1=0 never stalls.
REQ-015 A warp with stalled=1 SHALL remain in active_mask; the scheduler gates on active & ~stalled.
REQ-016 tmc with all-zero mask on a stalled warp SHALL deactivate it and leave stalled and barrier state unchanged.

Reset
REQ-017 While reset=0 at a clk edge, state SHALL reset as follows:
- active_mask=0...01, stalled_mask=0.
- tmask[0]=all ones; tmask[w>0]=0.
- All stack occupancies 0; all barrier counts and masks 0.
- pc_upd_valid=0, err_ovf=0, err_unf=0.
REQ-018 Reset mid-operation SHALL discard any command presented in the same cycle.

Verification
REQ-019 After reset (NUM_WARPS=4), wspawn wid=0, wmask=4'b1110, pc=0x80000100 -> next cycle active=4'b1111, tmask[1..3]=4'b0001, pc_upd_valid=1, wmask=4'b1110, pc=0x80000100.
REQ-020 Warp 0 tmask=1111, split dvg then=0011 else=1100 next_pc=0x200 -> tmask=0011.
- First join dvg -> tmask=1100, pc_upd_pc=0x200, wmask=0001.
- Second join dvg -> tmask=1111, no pc_upd, err_unf=0.
REQ-021 Three dvg splits on warp 0 with IPDOM_DEPTH=4 -> first two accepted (occupancy 4), third gives err_ovf=1 with tmask unchanged; join on empty stack of warp 1 -> err_unf=1.
REQ-022 Barrier id 2, size_m1=2: warps 0 and 1 arrive -> stalled=0011; warp 3 arrives -> stalled=0000 next cycle and id 2 count=0.
REQ-023 tmc wid=2 mask=0000 -> active[2]=0; same cycle tmc+join on warp 0 -> only tmc applied, stack unchanged.
REQ-024 Assert reset=0 for one cycle during a pending barrier and non-empty stack -> all state returns to REQ-017 values.
